alu_multibyte_seq: RTL and testbench

- Multi-cycle controller that sequences the team's 8-bit ALU to perform NBYTES-wide (default 32-bit) arithmetic, logic, compare and shift operations, one byte per clock.
- Drives the ALU's SEL/A/B/CIN ports and chains carry/borrow between byte lanes.
- Accumulates the wide result, carry and zero flags.
- Sits between the CPU control unit (START/DONE handshake) and a single ALU instance in the parent.

---
 rtl/alu_multibyte_seq_pkg.sv | 50 +++++
 rtl/alu_multibyte_seq.sv | 137 +++++++++++++
 tb/tb_alu_multibyte_seq.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_multibyte_seq_pkg.sv
// Shared definitions for the multi-byte ALU sequencer: ALU select codes,
// operation and state encodings, and byte-lane access helpers.
package alu_seq_pkg;

  localparam logic [3:0] SEL_ADD  = 4'd0;
  localparam logic [3:0] SEL_ADDC = 4'd1;
  localparam logic [3:0] SEL_SUB  = 4'd2;
  localparam logic [3:0] SEL_SUBC = 4'd3;
  localparam logic [3:0] SEL_AND  = 4'd5;
  localparam logic [3:0] SEL_OR   = 4'd6;
  localparam logic [3:0] SEL_XOR  = 4'd7;
  localparam logic [3:0] SEL_LSL  = 4'd9;
  localparam logic [3:0] SEL_LSR  = 4'd10;
  localparam logic [3:0] SEL_MOV  = 4'd14;

  localparam int unsigned MAX_BYTES = 8;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_CMP = 3'd2,
    OP_AND = 3'd3,
    OP_OR  = 3'd4,
    OP_XOR = 3'd5,
    OP_LSL = 3'd6,
    OP_LSR = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  // Lane helpers operate on a maximum-width vector; callers zero-extend.
  function automatic logic [7:0] lane_get(input logic [8*MAX_BYTES-1:0] v,
                                          input logic [2:0] k);
    return v[{k, 3'b000} +: 8];
  endfunction

  function automatic logic [8*MAX_BYTES-1:0] lane_put(input logic [8*MAX_BYTES-1:0] v,
                                                      input logic [2:0] k,
                                                      input logic [7:0] b);
    logic [8*MAX_BYTES-1:0] r;
    r = v;
    r[{k, 3'b000} +: 8] = b;
    return r;
  endfunction

endpackage

// File: rtl/alu_multibyte_seq.sv
// Sequences an external 8-bit ALU over NBYTES byte lanes, one lane per clock,
// chaining carry/borrow/shift bits and accumulating the wide result and flags.
module alu_multibyte_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned NBYTES = 4
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  START,
  input  logic [2:0]            OP,
  input  logic                  CIN,
  input  logic [8*NBYTES-1:0]   A_IN,
  input  logic [8*NBYTES-1:0]   B_IN,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [8*NBYTES-1:0]   RES,
  output logic                  C_OUT,
  output logic                  Z_OUT,
  output logic [3:0]            ALU_SEL,
  output logic [7:0]            ALU_A,
  output logic [7:0]            ALU_B,
  output logic                  ALU_CIN,
  input  logic [7:0]            ALU_RESULT,
  input  logic                  ALU_C,
  input  logic                  ALU_Z
);

  localparam int unsigned W    = 8 * NBYTES;
  localparam logic [2:0]  LAST = 3'(NBYTES - 1);

  state_t         state;
  op_t            op_q;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [2:0]     idx;
  logic [2:0]     lane;
  logic           carry;
  logic           zacc;

  // LSR walks from the top lane down so the shift-in bit enters at the MSB.
  always_comb begin
    lane = (op_q == OP_LSR) ? (LAST - idx) : idx;
  end

  always_comb begin
    ALU_SEL = SEL_MOV;
    ALU_A   = '0;
    ALU_B   = '0;
    ALU_CIN = 1'b0;
    if (state == RUN) begin
      ALU_A   = lane_get(64'(a_q), lane);
      ALU_B   = lane_get(64'(b_q), lane);
      ALU_CIN = carry;
      case (op_q)
        OP_ADD:         ALU_SEL = SEL_ADDC;
        OP_SUB, OP_CMP: ALU_SEL = SEL_SUBC;
        OP_AND: begin
          ALU_SEL = SEL_AND;
          ALU_CIN = 1'b0;
        end
        OP_OR: begin
          ALU_SEL = SEL_OR;
          ALU_CIN = 1'b0;
        end
        OP_XOR: begin
          ALU_SEL = SEL_XOR;
          ALU_CIN = 1'b0;
        end
        OP_LSL: begin
          ALU_SEL = SEL_LSL;
          ALU_B   = '0;
        end
        OP_LSR: begin
          ALU_SEL = SEL_LSR;
          ALU_B   = '0;
        end
        default: ALU_SEL = SEL_MOV;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= IDLE;
      op_q  <= OP_ADD;
      a_q   <= '0;
      b_q   <= '0;
      idx   <= '0;
      carry <= 1'b0;
      zacc  <= 1'b0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
      RES   <= '0;
      C_OUT <= 1'b0;
      Z_OUT <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            op_q  <= op_t'(OP);
            a_q   <= A_IN;
            b_q   <= B_IN;
            idx   <= '0;
            // A compare is a pure subtraction; the incoming borrow is discarded.
            carry <= (op_t'(OP) == OP_CMP) ? 1'b0 : CIN;
            zacc  <= 1'b1;
            BUSY  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          carry <= ALU_C;
          zacc  <= zacc & ALU_Z;
          if (op_q != OP_CMP) begin
            RES <= W'(lane_put(64'(RES), lane, ALU_RESULT));
          end
          if (idx == LAST) begin
            BUSY  <= 1'b0;
            state <= FIN;
          end else begin
            idx <= idx + 3'd1;
          end
        end
        FIN: begin
          DONE  <= 1'b1;
          C_OUT <= carry;
          Z_OUT <= zacc;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multibyte_seq.sv
// Scoreboard bench for alu_multibyte_seq with an 8-bit ALU model standing in
// for the parent's ALU and a whole-word reference model for expected results.
module tb_alu_multibyte_seq;
  import alu_seq_pkg::*;

  localparam int unsigned NB = 4;
  localparam int unsigned W  = 8 * NB;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [2:0]    op    = '0;
  logic          cin   = 1'b0;
  logic [W-1:0]  a_in  = '0;
  logic [W-1:0]  b_in  = '0;
  logic          busy, done, c_out, z_out;
  logic [W-1:0]  res;
  logic [3:0]    alu_sel;
  logic [7:0]    alu_a, alu_b, alu_result;
  logic          alu_cin, alu_c, alu_z;

  alu_multibyte_seq #(.NBYTES(NB)) dut (
    .CLK(clk), .RST_N(rst_n), .START(start), .OP(op), .CIN(cin),
    .A_IN(a_in), .B_IN(b_in), .BUSY(busy), .DONE(done), .RES(res),
    .C_OUT(c_out), .Z_OUT(z_out), .ALU_SEL(alu_sel), .ALU_A(alu_a),
    .ALU_B(alu_b), .ALU_CIN(alu_cin), .ALU_RESULT(alu_result),
    .ALU_C(alu_c), .ALU_Z(alu_z)
  );

  always #5 clk = ~clk;

  // Byte-wide ALU behaviour as seen by the sequencer.
  always_comb begin
    logic [8:0] t;
    t = '0;
    case (alu_sel)
      4'd1:  t = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};
      4'd3:  t = {1'b0, alu_a} - {1'b0, alu_b} - {8'd0, alu_cin};
      4'd5:  t = {1'b0, alu_a & alu_b};
      4'd6:  t = {1'b0, alu_a | alu_b};
      4'd7:  t = {1'b0, alu_a ^ alu_b};
      4'd9:  t = {alu_a[7], alu_a[6:0], alu_cin};
      4'd10: t = {alu_a[0], alu_cin, alu_a[7:1]};
      default: t = {1'b0, alu_a};
    endcase
    alu_result = t[7:0];
    alu_c      = t[8];
    alu_z      = (t[7:0] == 8'd0);
  end

  typedef struct packed {
    logic [W-1:0] res;
    logic         c;
    logic         z;
  } exp_t;

  exp_t          sbq[$];
  logic [W-1:0]  last_res = '0;
  int            passed = 0;
  int            total  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act === expv) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  function automatic exp_t ref_op(input logic [2:0] o, input logic ci,
                                  input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [W-1:0] prev);
    exp_t       e;
    logic [W:0] wide;
    e = '0;
    case (o)
      3'd0: begin
        wide  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
        e.res = wide[W-1:0];
        e.c   = wide[W];
      end
      3'd1: begin
        wide  = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, ci};
        e.res = wide[W-1:0];
        e.c   = wide[W];
      end
      3'd2: begin
        e.res = prev;
        e.c   = (a < b);
      end
      3'd3: e.res = a & b;
      3'd4: e.res = a | b;
      3'd5: e.res = a ^ b;
      3'd6: begin
        e.res = {a[W-2:0], ci};
        e.c   = a[W-1];
      end
      default: begin
        e.res = {ci, a[W-1:1]};
        e.c   = a[0];
      end
    endcase
    e.z = (o == 3'd2) ? (a == b) : (e.res == '0);
    return e;
  endfunction

  // Monitor: every DONE pulse consumes one expected response.
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      if (sbq.size() == 0) begin
        total++;
        $display("FAIL unexpected_done: got DONE=1 expected no pending operation");
      end else begin
        e = sbq.pop_front();
        chk("res",   64'(res),   64'(e.res));
        chk("c_out", 64'(c_out), 64'(e.c));
        chk("z_out", 64'(z_out), 64'(e.z));
      end
    end
  end

  // mode: 0 plain, 1 START pulse mid-RUN, 2 reset at idx=2, 3 START pulse in FIN
  task automatic do_op(input logic [2:0] o, input logic ci, input logic [W-1:0] a,
                       input logic [W-1:0] b, input int unsigned mode);
    exp_t        e;
    int unsigned k;
    int unsigned busy_n;
    @(negedge clk);
    op = o; cin = ci; a_in = a; b_in = b; start = 1'b1;
    e = ref_op(o, ci, a, b, last_res);
    sbq.push_back(e);
    @(posedge clk); #1;
    start  = 1'b0;
    busy_n = busy ? 1 : 0;
    k = 0;
    while (!done && k < 20) begin
      if ((mode == 1 && k == 1) || (mode == 3 && k == NB)) begin
        start = 1'b1;
        op    = 3'($urandom);
        a_in  = $urandom;
        b_in  = $urandom;
      end
      if (mode == 2 && k == 2) rst_n = 1'b0;
      @(posedge clk); #1;
      k++;
      start = 1'b0;
      if (mode == 2 && k == 3) begin
        rst_n = 1'b1;
        chk("rst_busy",  64'(busy),    64'(0));
        chk("rst_done",  64'(done),    64'(0));
        chk("rst_res",   64'(res),     64'(0));
        chk("rst_c",     64'(c_out),   64'(0));
        chk("rst_z",     64'(z_out),   64'(0));
        chk("rst_sel",   64'(alu_sel), 64'(SEL_MOV));
        void'(sbq.pop_back());
        last_res = '0;
        repeat (NB + 4) @(posedge clk);
        #1;
        return;
      end
      if (busy) busy_n++;
    end
    chk("latency",     64'(k),      64'(NB + 1));
    chk("busy_cycles", 64'(busy_n), 64'(NB));
    last_res = e.res;
    @(posedge clk); #1;
    chk("done_pulse", 64'(done), 64'(0));
    chk("idle_after", 64'(busy), 64'(0));
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("init_busy", 64'(busy),    64'(0));
    chk("init_done", 64'(done),    64'(0));
    chk("init_res",  64'(res),     64'(0));
    chk("init_c",    64'(c_out),   64'(0));
    chk("init_z",    64'(z_out),   64'(0));
    chk("init_sel",  64'(alu_sel), 64'(SEL_MOV));
    chk("init_a",    64'(alu_a),   64'(0));
    rst_n = 1'b1;

    do_op(3'd0, 1'b0, 32'h0000FFFF, 32'h00000001, 0);
    do_op(3'd0, 1'b0, 32'hFFFFFFFF, 32'h00000001, 0);
    do_op(3'd1, 1'b0, 32'h00000000, 32'h00000001, 0);
    do_op(3'd2, 1'b1, 32'h12345678, 32'h12345678, 0);
    do_op(3'd2, 1'b0, 32'h00000001, 32'h00000002, 0);
    do_op(3'd7, 1'b1, 32'h00000101, 32'h0, 0);
    do_op(3'd6, 1'b0, 32'h80000001, 32'h0, 0);
    do_op(3'd5, 1'b0, 32'hA5A5A5A5, 32'hA5A5A5A5, 1);
    do_op(3'd0, 1'b1, 32'h0F0F0F0F, 32'h12345678, 2);
    do_op(3'd0, 1'b1, 32'h7FFFFFFF, 32'h00000000, 0);
    do_op(3'd1, 1'b1, 32'h00010000, 32'h00000000, 3);

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
      do_op(3'($urandom_range(0, 7)), 1'($urandom), ra, rb,
            ($urandom_range(0, 3) == 0) ? 1 : (($urandom_range(0, 3) == 0) ? 3 : 0));
    end

    repeat (10) @(posedge clk);
    #1;
    chk("queue_empty", 64'(sbq.size()), 64'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
